// File: rtl/mod_2011_pkg.sv
// Shared constants and state encoding for the 300-bit operand path that
// feeds the mod-2011 reducer.
package mod_2011_pkg;

  // Operand geometry: NUM_WORDS words of WORD_W bits make one operand.
  localparam int LD_WORD_W    = 20;
  localparam int LD_NUM_WORDS = 15;
  localparam int OP_W         = 300;

  // Loader states.
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,   // assembling words into X
    ST_HOLD    = 2'd1,   // complete operand presented, waiting for x_ready
    ST_DRAIN   = 2'd2    // overlong operand, discarding until in_last
  } loader_state_t;

  // Width of a counter able to index 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/x_300_loader.sv
// Serial-to-parallel loader: collects WORD_W-bit words, least-significant
// word first, into a 300-bit operand X for the mod-2011 reducer. Short
// operands are zero-extended; overlong operands are flagged and dropped.
module x_300_loader
  import mod_2011_pkg::*;
#(
  parameter int WORD_W    = LD_WORD_W,
  parameter int NUM_WORDS = LD_NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OP_W:1]     X,
  output logic              x_valid,
  input  logic              x_ready,
  output logic              err_len
);

  localparam int K_W = cnt_w(NUM_WORDS);

  loader_state_t        r_state;
  logic [K_W-1:0]       r_k;
  logic [OP_W:1]        r_x;
  logic                 r_x_valid;
  logic                 r_err_len;
  logic                 r_in_ready;

  logic                 w_accept;
  logic                 w_last_slot;
  logic [NUM_WORDS-1:0] w_word_we;

  // in_ready comes straight from a register, so x_ready never reaches it
  // combinationally and nothing is accepted in the handshake cycle.
  assign w_accept    = in_valid && r_in_ready;
  assign w_last_slot = (r_k == K_W'(NUM_WORDS - 1));

  // One-hot write enable per word slot of X.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_we
      assign w_word_we[gi] = w_accept && (r_state == ST_COLLECT) && (r_k == K_W'(gi));
    end
  endgenerate

  // Loader FSM: state, word counter, operand register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_COLLECT;
      r_k        <= '0;
      r_x        <= '0;
      r_x_valid  <= 1'b0;
      r_err_len  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_err_len <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (w_word_we[i]) r_x[WORD_W*i+1 +: WORD_W] <= in_data;
            end
            if (in_last) begin
              // in_last wins even on the final slot: the operand is complete.
              r_state    <= ST_HOLD;
              r_x_valid  <= 1'b1;
              r_in_ready <= 1'b0;
            end else if (w_last_slot) begin
              // Slots exhausted without in_last: flag and drop the rest.
              r_state   <= ST_DRAIN;
              r_err_len <= 1'b1;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_x_valid && x_ready) begin
            r_state    <= ST_COLLECT;
            r_k        <= '0;
            r_x        <= '0;
            r_x_valid  <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_accept && in_last) begin
            r_state <= ST_COLLECT;
            r_k     <= '0;
            r_x     <= '0;
          end
        end
        default: begin
          r_state    <= ST_COLLECT;
          r_k        <= '0;
          r_x        <= '0;
          r_x_valid  <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign X        = r_x;
  assign x_valid  = r_x_valid;
  assign err_len  = r_err_len;

endmodule

// File: tb/tb_x_300_loader.sv
// Directed and random bench for x_300_loader with an expected-operand queue.
`timescale 1ns/1ps
module tb_x_300_loader;
  import mod_2011_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [19:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [300:1]  X;
  logic          x_valid;
  logic          x_ready;
  logic          err_len;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [299:0]  exp_q[$];
  logic [299:0]  cur_exp;
  logic [19:0]   words[16];

  x_300_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .X        (X),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    n_checks++;
    assert (got == exp) else begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // Present one word for one clock edge, then put junk on the idle bus.
  task automatic send_word(input logic [19:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = 20'($urandom());
  endtask

  task automatic idle_cycle();
    in_last = 1'($urandom_range(0, 1));
    in_data = 20'($urandom());
    @(posedge clk);
    #1;
  endtask

  // Send words[0..n-1] (n <= 15) as one operand and queue its expected X.
  task automatic send_operand(input int n, input bit gaps);
    cur_exp = '0;
    for (int i = 0; i < n; i++) begin
      send_word(words[i], (i == n - 1));
      cur_exp[20*i +: 20] = words[i];
      if (gaps && i != n - 1) idle_cycle();
    end
    exp_q.push_back(cur_exp);
    $display("tb: sent operand n=%0d gaps=%0d", n, gaps);
  endtask

  // Wait (bounded) for x_valid, compare X to the scoreboard, then handshake.
  task automatic expect_output(input string tag, output int waited);
    logic [299:0] e;
    waited = 0;
    while (x_valid !== 1'b1 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk1({tag, "_x_valid"}, x_valid, 1'b1);
    if (exp_q.size() == 0) begin
      e = '1;
      chki({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, "_X"}, X, e);
    chk1({tag, "_in_ready_hold"}, in_ready, 1'b0);
    x_ready = 1'b1;
    @(posedge clk);
    #1;
    x_ready = 1'b0;
    chk1({tag, "_x_valid_after"}, x_valid, 1'b0);
    chk({tag, "_X_cleared"}, X, '0);
    chk1({tag, "_in_ready_after"}, in_ready, 1'b1);
    $display("tb: %s operand checked after %0d wait cycles", tag, waited);
  endtask

  initial begin
    int w;
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    x_ready  = 1'b0;

    // Reset state.
    #12;
    chk("rst_X", X, '0);
    chk1("rst_x_valid", x_valid, 1'b0);
    chk1("rst_err_len", err_len, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);

    // Full 15-word operand 1..15, x_ready already high.
    for (int i = 0; i < 15; i++) words[i] = 20'(i + 1);
    x_ready = 1'b1;
    send_operand(15, 1'b0);
    chk1("full_valid_next_cycle", x_valid, 1'b1);
    chk("full_low_word", {280'd0, X[20:1]}, 300'd1);
    chk("full_high_word", {280'd0, X[300:281]}, 300'hF);
    expect_output("full", w);
    chki("full_latency", w, 0);

    // Single word, x_ready delayed; a word offered during HOLD is ignored.
    words[0] = 20'hABCDE;
    send_operand(1, 1'b0);
    chk("short_X", X, 300'hABCDE);
    for (int c = 0; c < 4; c++) begin
      chk1("short_hold_valid", x_valid, 1'b1);
      chk1("short_hold_ready", in_ready, 1'b0);
      in_data  = 20'h12345;
      in_last  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    expect_output("short", w);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    chk1("short_no_accept_in_handshake", x_valid, 1'b0);

    // Overlong operand: 16 words, last on the 16th.
    for (int i = 0; i < 16; i++) begin
      send_word(20'(32'h100 + i), (i == 15));
      chk1($sformatf("ovl_err_len_w%0d", i + 1), err_len, (i == 14));
      chk1("ovl_no_valid", x_valid, 1'b0);
    end
    idle_cycle();
    chk1("ovl_err_len_done", err_len, 1'b0);
    chk1("ovl_no_valid_end", x_valid, 1'b0);
    chk1("ovl_ready_end", in_ready, 1'b1);
    words[0] = 20'h00007; words[1] = 20'h00008; words[2] = 20'h00009;
    send_operand(3, 1'b0);
    expect_output("after_ovl", w);

    // Reset in the middle of an operand.
    for (int i = 0; i < 7; i++) send_word(20'($urandom()), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_X", X, '0);
    chk1("midrst_x_valid", x_valid, 1'b0);
    chk1("midrst_err_len", err_len, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk1("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 15; i++) words[i] = 20'($urandom());
    send_operand(15, 1'b0);
    expect_output("after_rst", w);

    // Gapped stream of 1..15 must match the gapless result.
    for (int i = 0; i < 15; i++) words[i] = 20'(i + 1);
    send_operand(15, 1'b1);
    expect_output("gapped", w);

    // Random operands of random length with random gaps and x_ready delay.
    for (int t = 0; t < 30; t++) begin
      int n;
      n = int'($urandom_range(1, 15));
      for (int i = 0; i < 15; i++) words[i] = 20'($urandom());
      send_operand(n, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) idle_cycle();
      expect_output($sformatf("rand%0d", t), w);
    end

    chki("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
